// File: rtl/wrr_pkg.sv
// Shared constants for the weighted round-robin arbiter: FSM encoding and
// parameter limits used by the interface, picker and top.
package wrr_pkg;

    localparam int N_MAX            = 16;
    localparam int WEIGHT_W_DEFAULT = 4;

    localparam logic [0:0] ARB  = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

endpackage

// File: rtl/wrr_n_arb_if.sv
// Request/grant/handshake bundle between the requesting channels (master)
// and the weighted round-robin arbiter (slave).
interface wrr_n_arb_if #(
    parameter int N        = 4,
    parameter int WEIGHT_W = wrr_pkg::WEIGHT_W_DEFAULT
);

    logic                  rr_ena;
    logic [N-1:0]          rr_req;
    logic [N*WEIGHT_W-1:0] cfg_weight;
    logic [N-1:0]          rr_result;
    logic                  rr_valid;
    logic                  rr_ready;
    logic                  rr_last;

    modport master (
        output rr_ena, rr_req, cfg_weight, rr_ready, rr_last,
        input  rr_result, rr_valid
    );

    modport slave (
        input  rr_ena, rr_req, cfg_weight, rr_ready, rr_last,
        output rr_result, rr_valid
    );

endinterface

// File: rtl/rr_n_pick.sv
// Cyclic first-one search: returns the first requester after cur, wrapping
// modulo N, with cur itself considered last. Purely combinational.
module rr_n_pick #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] cur,
    output logic [N-1:0]     pick
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDX_W'((int'(cur) + k) % N);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_n_arb.sv
// Weighted round-robin packet arbiter: a granted channel keeps the grant for
// up to eff_weight packets, with back-to-back re-grant at packet end.
module wrr_n_arb
    import wrr_pkg::*;
#(
    parameter int N        = 4,
    parameter int WEIGHT_W = WEIGHT_W_DEFAULT
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    wrr_n_arb_if.slave   bus
);

    localparam int IDX_W = $clog2(N);

    logic [0:0]          state_q, state_d;
    logic [IDX_W-1:0]    cur_q, cur_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [N-1:0]        result_q, result_d;

    logic [N-1:0]        rot_pick;
    logic [N-1:0]        cur_oh;
    logic [IDX_W-1:0]    rot_idx;
    logic [WEIGHT_W-1:0] rot_field;
    logic [WEIGHT_W-1:0] rot_weight;
    logic                stay;
    logic                others_req;
    logic                pkt_end;
    logic                grant_ok;

    rr_n_pick #(.N(N)) u_pick (
        .req  (bus.rr_req),
        .cur  (cur_q),
        .pick (rot_pick)
    );

    always_comb begin
        rot_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (rot_pick[i]) rot_idx = IDX_W'(i);
        end
    end

    // A zero quota still lets the channel send one packet per turn.
    assign rot_field  = bus.cfg_weight[rot_idx*WEIGHT_W +: WEIGHT_W];
    assign rot_weight = (rot_field == '0) ? WEIGHT_W'(1) : rot_field;

    assign cur_oh     = N'(1) << cur_q;
    assign stay       = bus.rr_req[cur_q] && (credit_q != '0);
    assign others_req = |(bus.rr_req & ~cur_oh);
    assign pkt_end    = (state_q == BUSY) && bus.rr_ready && bus.rr_last;
    assign grant_ok   = bus.rr_ena &&
                        (((state_q == ARB) && (|bus.rr_req)) ||
                         (pkt_end && (others_req || stay)));

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        credit_d = credit_q;
        result_d = result_q;
        if (grant_ok) begin
            state_d = BUSY;
            if (stay) begin
                result_d = cur_oh;
                credit_d = credit_q - 1'b1;
            end else begin
                result_d = rot_pick;
                cur_d    = rot_idx;
                credit_d = rot_weight - 1'b1;
            end
        end else if (pkt_end) begin
            state_d  = ARB;
            result_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge sys_clk) begin
        // NOTE: every state register is reset here; cur starts at N-1 so channel 0 wins first.
        if (sys_rst) begin
            state_q  <= ARB;
            cur_q    <= IDX_W'(N - 1);
            credit_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            credit_q <= credit_d;
            result_q <= result_d;
        end
    end

    assign bus.rr_result = result_q;
    assign bus.rr_valid  = (state_q == BUSY);

endmodule

// File: tb/tb_wrr_n_arb.sv
// Directed self-checking bench for wrr_n_arb: rotation, weights, multi-beat
// hold, weight-0 single requester, mid-packet reset and enable gating.
module tb_wrr_n_arb;

    localparam int N  = 4;
    localparam int WW = 4;

    logic sys_clk = 1'b0;
    logic sys_rst;
    int   checks   = 0;
    int   failures = 0;

    wrr_n_arb_if #(.N(N), .WEIGHT_W(WW)) bus ();

    wrr_n_arb #(.N(N), .WEIGHT_W(WW)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst        = 1'b1;
        bus.rr_ena     = 1'b0;
        bus.rr_req     = '0;
        bus.rr_ready   = 1'b0;
        bus.rr_last    = 1'b0;
        bus.cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.rr_valid, bus.rr_result} !== 5'b0_0000) begin
            failures++;
            $display("FAIL reset: got valid=%b result=%b, expected valid=0 result=0000",
                     bus.rr_valid, bus.rr_result);
        end
        tick();
        checks++;
        if ({bus.rr_valid, bus.rr_result} !== 5'b0_0000) begin
            failures++;
            $display("FAIL reset_idle: got valid=%b result=%b, expected valid=0 result=0000",
                     bus.rr_valid, bus.rr_result);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        bus.rr_ena   = 1'b1;
        bus.rr_ready = 1'b1;
        bus.rr_last  = 1'b1;
        bus.rr_req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({bus.rr_valid, bus.rr_result} !== {|exp_seq[k], exp_seq[k]}) begin
                failures++;
                $display("FAIL round_robin[%0d]: got valid=%b result=%b, expected valid=%b result=%b",
                         k, bus.rr_valid, bus.rr_result, |exp_seq[k], exp_seq[k]);
            end
        end
    endtask

    task automatic test_weighted();
        logic [N-1:0] exp_seq [7] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010,
                                      4'b0100, 4'b1000, 4'b0001};
        do_reset();
        bus.cfg_weight = {4'd1, 4'd1, 4'd3, 4'd1};
        bus.rr_ena     = 1'b1;
        bus.rr_ready   = 1'b1;
        bus.rr_last    = 1'b1;
        bus.rr_req     = 4'b1111;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if ({bus.rr_valid, bus.rr_result} !== {|exp_seq[k], exp_seq[k]}) begin
                failures++;
                $display("FAIL weighted[%0d]: got valid=%b result=%b, expected valid=%b result=%b",
                         k, bus.rr_valid, bus.rr_result, |exp_seq[k], exp_seq[k]);
            end
        end
    endtask

    task automatic test_multibeat();
        // Per step: inputs applied, then expected outputs after the next edge.
        logic [N-1:0] req_seq   [5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        logic         ready_seq [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic         last_seq  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [N-1:0] exp_seq   [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        do_reset();
        bus.rr_ena = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.rr_req   = req_seq[k];
            bus.rr_ready = ready_seq[k];
            bus.rr_last  = last_seq[k];
            tick();
            checks++;
            if ({bus.rr_valid, bus.rr_result} !== {|exp_seq[k], exp_seq[k]}) begin
                failures++;
                $display("FAIL multibeat[%0d]: got valid=%b result=%b, expected valid=%b result=%b",
                         k, bus.rr_valid, bus.rr_result, |exp_seq[k], exp_seq[k]);
            end
        end
    endtask

    task automatic test_single_weight0();
        // Credit is exhausted after every packet, so each re-grant passes through ARB.
        logic [N-1:0] exp_seq [7] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000,
                                      4'b1000, 4'b0000, 4'b0000};
        do_reset();
        bus.cfg_weight = {4'd0, 4'd1, 4'd1, 4'd1};
        bus.rr_ena     = 1'b1;
        bus.rr_ready   = 1'b1;
        bus.rr_last    = 1'b1;
        bus.rr_req     = 4'b1000;
        for (int k = 0; k < 7; k++) begin
            if (k == 5) bus.rr_req = 4'b0000;
            tick();
            checks++;
            if ({bus.rr_valid, bus.rr_result} !== {|exp_seq[k], exp_seq[k]}) begin
                failures++;
                $display("FAIL single_w0[%0d]: got valid=%b result=%b, expected valid=%b result=%b",
                         k, bus.rr_valid, bus.rr_result, |exp_seq[k], exp_seq[k]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.rr_ena = 1'b1;
        bus.rr_req = 4'b0010;
        tick();
        checks++;
        if ({bus.rr_valid, bus.rr_result} !== 5'b1_0010) begin
            failures++;
            $display("FAIL rst_mid_grant: got valid=%b result=%b, expected valid=1 result=0010",
                     bus.rr_valid, bus.rr_result);
        end
        sys_rst = 1'b1;
        tick();
        checks++;
        if ({bus.rr_valid, bus.rr_result} !== 5'b0_0000) begin
            failures++;
            $display("FAIL rst_mid_abort: got valid=%b result=%b, expected valid=0 result=0000",
                     bus.rr_valid, bus.rr_result);
        end
        sys_rst    = 1'b0;
        bus.rr_req = 4'b0110;
        tick();
        checks++;
        if ({bus.rr_valid, bus.rr_result} !== 5'b1_0010) begin
            failures++;
            $display("FAIL rst_mid_regrant: got valid=%b result=%b, expected valid=1 result=0010",
                     bus.rr_valid, bus.rr_result);
        end
    endtask

    task automatic test_enable();
        do_reset();
        bus.rr_ena = 1'b0;
        bus.rr_req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({bus.rr_valid, bus.rr_result} !== 5'b0_0000) begin
                failures++;
                $display("FAIL ena_low[%0d]: got valid=%b result=%b, expected valid=0 result=0000",
                         k, bus.rr_valid, bus.rr_result);
            end
        end
        bus.rr_ena = 1'b1;
        tick();
        checks++;
        if ({bus.rr_valid, bus.rr_result} !== 5'b1_0001) begin
            failures++;
            $display("FAIL ena_grant: got valid=%b result=%b, expected valid=1 result=0001",
                     bus.rr_valid, bus.rr_result);
        end
        // Packet ends while disabled: no back-to-back grant even with requests pending.
        bus.rr_ena   = 1'b0;
        bus.rr_req   = 4'b0011;
        bus.rr_ready = 1'b1;
        bus.rr_last  = 1'b1;
        tick();
        checks++;
        if ({bus.rr_valid, bus.rr_result} !== 5'b0_0000) begin
            failures++;
            $display("FAIL ena_end_low: got valid=%b result=%b, expected valid=0 result=0000",
                     bus.rr_valid, bus.rr_result);
        end
        tick();
        checks++;
        if ({bus.rr_valid, bus.rr_result} !== 5'b0_0000) begin
            failures++;
            $display("FAIL ena_hold_low: got valid=%b result=%b, expected valid=0 result=0000",
                     bus.rr_valid, bus.rr_result);
        end
        bus.rr_ena = 1'b1;
        tick();
        checks++;
        if ({bus.rr_valid, bus.rr_result} !== 5'b1_0010) begin
            failures++;
            $display("FAIL ena_rotate: got valid=%b result=%b, expected valid=1 result=0010",
                     bus.rr_valid, bus.rr_result);
        end
    endtask

    initial begin
        sys_rst        = 1'b1;
        bus.rr_ena     = 1'b0;
        bus.rr_req     = '0;
        bus.rr_ready   = 1'b0;
        bus.rr_last    = 1'b0;
        bus.cfg_weight = '0;

        test_reset();
        test_round_robin();
        test_weighted();
        test_multibeat();
        test_single_weight0();
        test_reset_mid_packet();
        test_enable();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wrr_n_arb.md
WRR_N_ARB -- requirements
Module: wrr_n_arb

Interface
REQ-001 Parameter N, default 4, is the number of requesting channels; legal range 2..16.
REQ-002 Parameter WEIGHT_W, default 4, is the width of each per-channel weight field.
REQ-003 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 sys_rst  input  1  reset, synchronous and active-high.
REQ-005 rr_ena  input  1  arbitration enable; when low, no new grant is issued and the pointer and credit are frozen.
REQ-006 rr_req  input  N  per-channel request level; bit i high means channel i has a packet pending.
REQ-007 cfg_weight  input  N*WEIGHT_W  per-channel packet quota; field i occupies bits [i*WEIGHT_W +: WEIGHT_W]; must be static while rr_valid=1.
REQ-008 rr_result  output  N  registered one-hot grant; all zeros when no grant is active.
REQ-009 rr_valid  output  1  registered; high while a grant is active.
REQ-010 rr_ready  input  1  downstream beat accept from the granted channel's data path.
REQ-011 rr_last  input  1  qualifies the accepted beat as the final beat of the packet.

Function
REQ-012 The FSM SHALL have two states, ARB and BUSY.
REQ-013 In ARB with rr_ena=1 and rr_req!=0, the next rising edge SHALL load rr_result with the pick, set rr_valid=1 and enter BUSY; latency from request to grant is one cycle.
REQ-014 Pick rule, stay: if rr_req[cur]=1 and credit>0, the pick SHALL be cur and credit SHALL decrement by 1.
REQ-015 Pick rule, rotate: otherwise the pick SHALL be the first requesting channel searching cur+1, cur+2, ... with wrap-around modulo N (cur itself is searched last); cur SHALL become that channel and credit SHALL load eff_weight-1.
REQ-016 eff_weight SHALL equal cfg_weight field i, except that a weight of 0 SHALL be treated as 1.
REQ-017 In BUSY, rr_result and rr_valid SHALL hold regardless of rr_req and rr_ena.
REQ-018 A packet SHALL end only on a cycle with rr_valid & rr_ready & rr_last.
REQ-019 At the edge where a packet ends, if rr_ena=1 and rr_req excluding the current channel's bit is nonzero, or the current channel still has a request and credit>0, the next grant SHALL be loaded on that same edge with no bubble and the FSM SHALL stay in BUSY.
REQ-020 At the edge where a packet ends with no eligible next grant, rr_result SHALL become 0 and rr_valid 0, and the FSM SHALL enter ARB.
REQ-021 For the back-to-back case, rr_req[cur] SHALL be sampled on the packet-end cycle.
REQ-022 rr_ready without rr_last, or rr_last without rr_ready, SHALL not change state.
REQ-023 An unchanged rr_req with a single requester SHALL re-grant that channel every packet; its credit SHALL wrap by reloading per REQ-015.
REQ-024 rr_result SHALL always be one-hot or zero; rr_valid SHALL equal |rr_result.
REQ-025 The credit counter SHALL be WEIGHT_W bits wide and SHALL never underflow.

Reset
REQ-026 On sys_rst=1 at a clock edge: rr_result=0, rr_valid=0, state=ARB, cur=N-1, credit=0, so channel 0 has first priority.
REQ-027 Reset asserted mid-packet SHALL abort the grant at that edge; no partial state SHALL be retained.
REQ-028 Reset SHALL dominate rr_ena and the handshake inputs.

Structure
REQ-029 A package wrr_pkg SHALL hold the FSM state encoding (ARB, BUSY) and the constants N_MAX=16 and WEIGHT_W_DEFAULT=4.
REQ-030 The cyclic first-one search SHALL be a combinational sub-module rr_n_pick, with inputs req[N] and cur index and output one-hot pick, instantiated once.
REQ-031 The index width SHALL be $clog2(N).

Verification
REQ-032 Reset, then rr_req=4'b1111 with all weights 1 and single-beat packets (ready=last=1): grants SHALL be 0,1,2,3,0 on consecutive cycles, with no bubble after the first.
REQ-033 Weights {1,3,1,1} for ch0..ch3, all requesting, single-beat packets: grant sequence SHALL be 0,1,1,1,2,3,0.
REQ-034 Grant ch2 with 3-beat packet, ready toggling 1,0,1,1 and last on the 3rd accepted beat, rr_req[2] dropped mid-packet: rr_result SHALL stay 4'b0100 until the last beat is accepted.
REQ-035 Only ch3 requesting, weight 0, three packets: ch3 granted three times; rr_valid falls the cycle after its request drops at packet end.
REQ-036 sys_rst pulsed during BUSY of ch1: next cycle rr_valid=0 and rr_result=0; with rr_req=4'b0110 after reset, the first grant SHALL be ch1.
REQ-037 rr_ena=0 in ARB with rr_req=4'b0001 for 5 cycles: no grant; rr_ena=1: grant ch0 one cycle later.
